// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: redirect/hazard controls, instruction RAM
// bus, IF/ID register outputs, fault report and perf counters.
interface fetch_stage_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  stall;
   logic                  flush;
   logic                  branch_taken;
   logic [ADDR_WIDTH-1:0] branch_target;
   logic [ADDR_WIDTH-1:0] pc;
   logic [31:0]           instruction_in;
   logic                  if_id_valid;
   logic [ADDR_WIDTH-1:0] if_id_pc;
   logic [ADDR_WIDTH-1:0] if_id_pc_plus4;
   logic [31:0]           if_id_instruction;
   logic                  misaligned_exception;
   logic [ADDR_WIDTH-1:0] fault_addr;
   logic [31:0]           perf_fetched;
   logic [31:0]           perf_bubbles;

   modport master (
      input  stall,
      input  flush,
      input  branch_taken,
      input  branch_target,
      input  instruction_in,
      output pc,
      output if_id_valid,
      output if_id_pc,
      output if_id_pc_plus4,
      output if_id_instruction,
      output misaligned_exception,
      output fault_addr,
      output perf_fetched,
      output perf_bubbles
   );

   modport slave (
      output stall,
      output flush,
      output branch_taken,
      output branch_target,
      output instruction_in,
      input  pc,
      input  if_id_valid,
      input  if_id_pc,
      input  if_id_pc_plus4,
      input  if_id_instruction,
      input  misaligned_exception,
      input  fault_addr,
      input  perf_fetched,
      input  perf_bubbles
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, IF/ID register, misaligned-target fault.
// Optional perf counters enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
   input logic          clk,
   input logic          rst_n,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FAULT
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] pc;
      logic [ADDR_WIDTH-1:0] pc_plus4;
      logic [31:0]           instr;
   } if_id_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] fault_q, fault_d;
   if_id_t                ifid_q, ifid_d;
   logic                  load_valid;
   logic                  load_bubble;
   logic                  tgt_misaligned;

   assign pc_inc         = pc_q + ADDR_WIDTH'(4);
   assign tgt_misaligned = (bus.branch_target[1:0] != 2'b00);

   // State, PC, fault address and IF/ID register update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= BOOT;
         pc_q            <= RESET_PC;
         fault_q         <= '0;
         ifid_q.valid    <= 1'b0;
         ifid_q.pc       <= '0;
         ifid_q.pc_plus4 <= '0;
         ifid_q.instr    <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
         ifid_q  <= ifid_d;
      end
   end

   // Next state, next PC and IF/ID load selection
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fault_d     = fault_q;
      load_valid  = 1'b0;
      load_bubble = 1'b0;
      unique case (state_q)
         BOOT: begin
            load_bubble = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            if (bus.branch_taken && tgt_misaligned) begin
               state_d     = FAULT;
               fault_d     = bus.branch_target;
               load_bubble = 1'b1;
            end else if (bus.branch_taken) begin
               pc_d        = bus.branch_target;
               load_bubble = 1'b1;
            end else if (bus.stall) begin
               load_bubble = bus.flush;
            end else if (bus.flush) begin
               pc_d        = pc_inc;
               load_bubble = 1'b1;
            end else begin
               pc_d       = pc_inc;
               load_valid = 1'b1;
            end
         end
         FAULT: begin
            load_bubble = 1'b1;
            if (bus.branch_taken) begin
               if (tgt_misaligned) begin
                  fault_d = bus.branch_target;
               end else begin
                  pc_d    = bus.branch_target;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d     = BOOT;
            load_bubble = 1'b1;
         end
      endcase

      ifid_d = ifid_q;
      if (load_bubble) begin
         ifid_d.valid = 1'b0;
         ifid_d.instr = NOP_INSTR;
      end else if (load_valid) begin
         ifid_d.valid    = 1'b1;
         ifid_d.pc       = pc_q;
         ifid_d.pc_plus4 = pc_inc;
         ifid_d.instr    = bus.instruction_in;
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetched_q;
   logic [31:0] bubbles_q;

   // Count valid loads and bubble loads into IF/ID
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetched_q <= '0;
         bubbles_q <= '0;
      end else begin
         fetched_q <= fetched_q + {31'd0, load_valid};
         bubbles_q <= bubbles_q + {31'd0, load_bubble};
      end
   end

   assign bus.perf_fetched = fetched_q;
   assign bus.perf_bubbles = bubbles_q;
`else
   assign bus.perf_fetched = '0;
   assign bus.perf_bubbles = '0;
`endif

   assign bus.pc                   = pc_q;
   assign bus.if_id_valid          = ifid_q.valid;
   assign bus.if_id_pc             = ifid_q.pc;
   assign bus.if_id_pc_plus4       = ifid_q.pc_plus4;
   assign bus.if_id_instruction    = ifid_q.instr;
   assign bus.misaligned_exception = (state_q == FAULT);
   assign bus.fault_addr           = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, fault, wrap,
// flush and perf counters against hand-computed values.
module tb_fetch_stage;
   localparam int          AW  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   fetch_stage_if #(.ADDR_WIDTH(AW)) bus ();

   fetch_stage #(
      .ADDR_WIDTH(AW),
      .RESET_PC  (32'h0000_0100),
      .NOP_INSTR (NOP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   assign bus.instruction_in = 32'hA000_0000 ^ bus.pc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk_ifid(input string tag,
                           input logic [31:0] p,
                           input logic [31:0] pc_now);
      check({tag, ".valid"}, {31'd0, bus.if_id_valid}, 32'd1);
      check({tag, ".pc"}, bus.if_id_pc, p);
      check({tag, ".pc4"}, bus.if_id_pc_plus4, p + 32'd4);
      check({tag, ".instr"}, bus.if_id_instruction, 32'hA000_0000 ^ p);
      check({tag, ".fpc"}, bus.pc, pc_now);
   endtask

   task automatic chk_bubble(input string tag);
      check({tag, ".valid"}, {31'd0, bus.if_id_valid}, 32'd0);
      check({tag, ".instr"}, bus.if_id_instruction, NOP);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      bus.stall         = 1'b0;
      bus.flush         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      step(2);
      check("rst.pc", bus.pc, 32'h100);
      check("rst.valid", {31'd0, bus.if_id_valid}, 32'd0);
      check("rst.ifpc", bus.if_id_pc, 32'd0);
      check("rst.pc4", bus.if_id_pc_plus4, 32'd0);
      check("rst.instr", bus.if_id_instruction, NOP);
      check("rst.exc", {31'd0, bus.misaligned_exception}, 32'd0);
      check("rst.fault", bus.fault_addr, 32'd0);
      check("rst.pf", bus.perf_fetched, 32'd0);
      check("rst.pb", bus.perf_bubbles, 32'd0);

      rst_n = 1'b1;
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      step(1);
      chk_bubble("boot");
      check("boot.pc", bus.pc, 32'h100);
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      step(1);
      chk_ifid("f100", 32'h100, 32'h104);
      step(1);
      chk_ifid("f104", 32'h104, 32'h108);

      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk_ifid("stall", 32'h104, 32'h108);
      end
      bus.stall = 1'b0;
      step(1);
      chk_ifid("f108", 32'h108, 32'h10C);

      bus.stall         = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h200;
      step(1);
      chk_bubble("br");
      check("br.pc", bus.pc, 32'h200);
      check("br.ifpc", bus.if_id_pc, 32'h108);
      bus.stall        = 1'b0;
      bus.branch_taken = 1'b0;
      step(1);
      chk_ifid("f200", 32'h200, 32'h204);

      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h202;
      step(1);
      check("mis.exc", {31'd0, bus.misaligned_exception}, 32'd1);
      check("mis.fa", bus.fault_addr, 32'h202);
      check("mis.pc", bus.pc, 32'h204);
      chk_bubble("mis");
      bus.branch_taken = 1'b0;
      bus.flush        = 1'b1;
      step(1);
      check("flt.exc", {31'd0, bus.misaligned_exception}, 32'd1);
      check("flt.fa", bus.fault_addr, 32'h202);
      check("flt.pc", bus.pc, 32'h204);
      chk_bubble("flt");
      bus.flush         = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h303;
      step(1);
      check("relat.fa", bus.fault_addr, 32'h303);
      check("relat.exc", {31'd0, bus.misaligned_exception}, 32'd1);
      bus.branch_target = 32'h40;
      step(1);
      check("trap.exc", {31'd0, bus.misaligned_exception}, 32'd0);
      check("trap.pc", bus.pc, 32'h40);
      chk_bubble("trap");
      bus.branch_taken = 1'b0;
      step(1);
      chk_ifid("f40", 32'h40, 32'h44);

      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'hFFFF_FFFC;
      step(1);
      check("wrap.pc0", bus.pc, 32'hFFFF_FFFC);
      bus.branch_taken = 1'b0;
      step(1);
      chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0);
      check("wrap.pc4", bus.if_id_pc_plus4, 32'h0);
      check("wrap.exc", {31'd0, bus.misaligned_exception}, 32'd0);
      step(1);
      chk_ifid("f0", 32'h0, 32'h4);

      bus.flush = 1'b1;
      step(1);
      chk_bubble("fl");
      check("fl.pc", bus.pc, 32'h8);
      check("fl.ifpc", bus.if_id_pc, 32'h0);
      bus.flush = 1'b0;

      rst_n = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h500;
      step(1);
      check("mrst.pc", bus.pc, 32'h100);
      check("mrst.valid", {31'd0, bus.if_id_valid}, 32'd0);
      check("mrst.pf", bus.perf_fetched, 32'd0);
      check("mrst.pb", bus.perf_bubbles, 32'd0);
      bus.branch_taken = 1'b0;
      rst_n = 1'b1;
      step(5);
      bus.flush = 1'b1;
      step(1);
      bus.flush = 1'b0;
      bus.stall = 1'b1;
      step(2);
      bus.stall = 1'b0;
      check("perf.pc", bus.pc, 32'h114);
`ifdef FETCH_PERF_COUNTERS_EN
      check("perf.f", bus.perf_fetched, 32'd4);
      check("perf.b", bus.perf_bubbles, 32'd2);
`else
      check("perf.f", bus.perf_fetched, 32'd0);
      check("perf.b", bus.perf_bubbles, 32'd0);
`endif
      rst_n = 1'b0;
      step(1);
      check("prst.f", bus.perf_fetched, 32'd0);
      check("prst.b", bus.perf_bubbles, 32'd0);
      rst_n = 1'b1;
      step(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of instruction_ram.
- Owns the program counter and drives it to instruction_ram's PC input. Captures the combinational instruction word returned that cycle into the IF/ID pipeline register.
- Handles stall, flush, branch redirect and misaligned-target faults.
- Decode consumes the IF/ID outputs.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction_ram address.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word inserted for bubbles (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hazard unit holds PC and IF/ID register.
- flush  input  1  squash IF/ID contents to a bubble.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  ADDR_WIDTH  redirect address.
- pc  output  ADDR_WIDTH  current fetch address to instruction_ram.
- instruction_in  input  32  word from instruction_ram for address pc, same cycle.
- if_id_valid  output  1  IF/ID register holds a real instruction.
- if_id_pc  output  ADDR_WIDTH  PC of the registered instruction.
- if_id_pc_plus4  output  ADDR_WIDTH  if_id_pc+4, for link writes.
- if_id_instruction  output  32  registered instruction, or NOP_INSTR when invalid.
- misaligned_exception  output  1  high while in FAULT.
- fault_addr  output  ADDR_WIDTH  offending branch_target, valid while in FAULT.
- perf_fetched  output  32  see Optional Feature.
- perf_bubbles  output  32  see Optional Feature.

Behaviour:
- Reset: synchronous. On a posedge with rst_n=0, all of the following load:
  - pc=RESET_PC
  - if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instruction=NOP_INSTR
  - misaligned_exception=0, fault_addr=0
  - perf counters=0
  - state=BOOT
- Reset asserted mid-operation overrides every other input that cycle.
- State machine has three states: BOOT, RUN, FAULT.
- BOOT:
  - Lasts one cycle after reset is released.
  - IF/ID loads a bubble. pc holds RESET_PC.
  - Next state is RUN unconditionally; stall and flush are ignored.
- RUN, evaluated in this priority order:
  1. branch_taken with branch_target[1:0]!=0:
     - Go to FAULT and latch fault_addr=branch_target.
     - pc holds. IF/ID loads a bubble.
  2. branch_taken with aligned target:
     - pc<=branch_target. IF/ID loads a bubble (the wrong-path fetch is squashed).
     - Redirect overrides stall.
  3. stall=1:
     - pc holds. IF/ID holds all fields.
     - flush together with stall still squashes: IF/ID loads a bubble, pc holds.
  4. flush=1:
     - IF/ID loads a bubble. pc<=pc+4.
  5. Otherwise:
     - if_id_valid<=1, if_id_pc<=pc, if_id_pc_plus4<=pc+4, if_id_instruction<=instruction_in.
     - pc<=pc+4.
- FAULT:
  - misaligned_exception=1. fault_addr is stable.
  - pc holds. IF/ID loads a bubble every cycle. stall and flush are ignored.
  - Exits only on branch_taken with an aligned target (trap handler redirect): pc<=branch_target, go to RUN, misaligned_exception deasserts on the same edge.
  - A misaligned branch_taken while in FAULT re-latches fault_addr and stays in FAULT.
- Bubble: valid=0, instruction=NOP_INSTR. if_id_pc and if_id_pc_plus4 are not changed by a bubble.
- Arithmetic:
  - pc+4 is modulo 2^ADDR_WIDTH, so pc={ADDR_WIDTH{1'b1}}-3 wraps to 0 with no fault.
  - if_id_pc_plus4 wraps identically.
- Latency: instruction at address A appears on if_id_* one cycle after pc=A, given no stall, flush or redirect.
- Outputs pc and if_id_* are registers only. instruction_in is never combinationally forwarded.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - perf_fetched increments on every edge that loads a valid instruction into IF/ID.
  - perf_bubbles increments on every edge that loads a bubble, including BOOT and FAULT cycles. Stall-hold cycles do not increment it.
  - Both counters are 32 bits, wrap at 2^32 and reset to 0.
- Undefined:
  - Both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset released with RESET_PC=0x100, no stalls, memory holding sequential words:
  - BOOT cycle has if_id_valid=0.
  - Next edges produce if_id_pc=0x100, 0x104, 0x108 with the matching instructions.
  - if_id_pc_plus4=0x104, 0x108, 0x10C.
- stall held 3 cycles at pc=0x108:
  - pc stays 0x108 and IF/ID holds 0x104's data.
  - Release gives if_id_pc=0x108.
- branch_taken=1 with target 0x200 while stall=1:
  - pc=0x200 next cycle and IF/ID is a bubble (valid=0, NOP_INSTR).
  - Following edge gives if_id_pc=0x200.
- branch_taken with target 0x202:
  - misaligned_exception=1, fault_addr=0x202, pc unchanged, bubbles continue.
  - A later aligned branch to 0x40 clears the exception and next if_id_pc=0x40.
- pc=0xFFFF_FFFC, run freely:
  - Next pc=0x0. if_id_pc_plus4=0x0 for the 0xFFFF_FFFC instruction.
- FETCH_PERF_COUNTERS_EN defined, reset, then 5 free cycles, 1 flush and 2 stall cycles:
  - perf_fetched=4 and perf_bubbles=2 (BOOT plus flush).
  - Reset mid-run zeros both counters.
